// File: rtl/axis_hdr_insert_arbiter.sv
// Packet-level round-robin arbiter that shares one header-insert datapath among NUM_SRC sources.
// Each grant forwards a header and then a payload, and holds until the inserter reports the packet has left.
module axis_hdr_insert_arbiter #(
  parameter  int NUM_SRC = 4,
  parameter  int TIMEOUT = 1024,
  localparam int IDW     = $clog2(NUM_SRC),
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_SRC-1:0]      s_valid,
  input  logic [32*NUM_SRC-1:0]   s_data,
  input  logic [4*NUM_SRC-1:0]    s_keep,
  input  logic [NUM_SRC-1:0]      s_last,
  output logic [NUM_SRC-1:0]      s_ready,
  input  logic [NUM_SRC-1:0]      h_valid,
  input  logic [32*NUM_SRC-1:0]   h_data,
  input  logic [4*NUM_SRC-1:0]    h_keep,
  input  logic [2*NUM_SRC-1:0]    h_bcnt,
  output logic [NUM_SRC-1:0]      h_ready,
  output logic                    ins_valid_in,
  output logic [31:0]             ins_data_in,
  output logic [3:0]              ins_keep_in,
  output logic                    ins_last_in,
  input  logic                    ins_ready_in,
  output logic                    ins_valid_insert,
  output logic [31:0]             ins_data_insert,
  output logic [3:0]              ins_keep_insert,
  output logic [1:0]              ins_byte_insert_cnt,
  input  logic                    ins_ready_insert,
  input  logic                    pkt_done,
  output logic [IDW-1:0]          grant_id,
  output logic                    busy,
  output logic                    err_timeout
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, win;
  logic [TW-1:0]  timer;
  logic           any_req, to_hit;

  // Rotating priority: the lowest offset from rr_ptr wins, so scan offsets high to low.
  always_comb begin
    win     = rr_ptr;
    any_req = |h_valid;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (h_valid[(int'(rr_ptr) + i) % NUM_SRC])
        win = IDW'((int'(rr_ptr) + i) % NUM_SRC);
  end

  // Data and keep muxes follow the grant unconditionally; only the valids are gated.
  assign ins_data_insert     = h_data[32*grant_id +: 32];
  assign ins_keep_insert     = h_keep[4*grant_id +: 4];
  assign ins_byte_insert_cnt = h_bcnt[2*grant_id +: 2];
  assign ins_data_in         = s_data[32*grant_id +: 32];
  assign ins_keep_in         = s_keep[4*grant_id +: 4];
  assign ins_last_in         = s_last[grant_id];
  assign busy                = (state != IDLE);

  always_comb begin
    state_nxt        = state;
    h_ready          = '0;
    s_ready          = '0;
    ins_valid_insert = 1'b0;
    ins_valid_in     = 1'b0;
    to_hit           = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = HDR;
      HDR: begin
        ins_valid_insert  = h_valid[grant_id];
        h_ready[grant_id] = ins_ready_insert;
        if (h_valid[grant_id] && ins_ready_insert) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        ins_valid_in      = s_valid[grant_id];
        s_ready[grant_id] = ins_ready_in;
        if (s_valid[grant_id] && ins_ready_in && s_last[grant_id])
          state_nxt = pkt_done ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (pkt_done) state_nxt = IDLE;
        else if (timer == TW'(TIMEOUT-1)) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) grant_id <= win;
      if (state != IDLE && state_nxt == IDLE)
        rr_ptr <= (grant_id == IDW'(NUM_SRC-1)) ? '0 : grant_id + 1'b1;
      timer <= (state == DRAIN && state_nxt == DRAIN) ? timer + 1'b1 : '0;
      if (to_hit) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_hdr_insert_arbiter.sv
// Directed bench for axis_hdr_insert_arbiter: table of arbitration vectors plus multi-cycle sequences.
module tb_axis_hdr_insert_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk = 0, rstn = 0;
  logic [N-1:0]    s_valid = '0, s_last = '0, h_valid = '0;
  logic [32*N-1:0] s_data = '0, h_data = '0;
  logic [4*N-1:0]  s_keep = '0, h_keep = '0;
  logic [2*N-1:0]  h_bcnt = '0;
  logic [N-1:0]    s_ready, h_ready;
  logic        ins_valid_in, ins_last_in, ins_ready_in = 0;
  logic [31:0] ins_data_in, ins_data_insert;
  logic [3:0]  ins_keep_in, ins_keep_insert;
  logic        ins_valid_insert, ins_ready_insert = 0, pkt_done = 0;
  logic [1:0]  ins_byte_insert_cnt, grant_id;
  logic        busy, err_timeout;

  int tests = 0, fails = 0;

  axis_hdr_insert_arbiter #(.NUM_SRC(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_ready(s_ready),
    .h_valid(h_valid), .h_data(h_data), .h_keep(h_keep), .h_bcnt(h_bcnt), .h_ready(h_ready),
    .ins_valid_in(ins_valid_in), .ins_data_in(ins_data_in), .ins_keep_in(ins_keep_in),
    .ins_last_in(ins_last_in), .ins_ready_in(ins_ready_in),
    .ins_valid_insert(ins_valid_insert), .ins_data_insert(ins_data_insert),
    .ins_keep_insert(ins_keep_insert), .ins_byte_insert_cnt(ins_byte_insert_cnt),
    .ins_ready_insert(ins_ready_insert), .pkt_done(pkt_done),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] req; int gnt; } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic set_beat(input int b, input logic last);
    for (int i = 0; i < N; i++) s_data[32*i +: 32] = 32'hA000_0000 + 32'(i*256 + b);
    s_last = last ? '1 : '0;
  endtask

  task automatic do_reset;
    rstn = 0; h_valid = '0; s_valid = '0; s_last = '0; pkt_done = 0;
    tick; tick;
    rstn = 1;
  endtask

  // Runs one packet from IDLE; caller has set h_valid. done_dly: 0 same cycle, >0 cycles after last, <0 never.
  task automatic do_pkt(input int g, input int nbeats, input int done_dly, input int stall);
    int n;
    ins_ready_insert = (stall == 0); ins_ready_in = 1;
    s_valid = '1; set_beat(0, 0);
    #1 chk("idle_busy", busy, 0);
    chk("idle_vins", ins_valid_insert, 0);
    chk("idle_vin", ins_valid_in, 0);
    tick;
    chk("grant", grant_id, g);
    chk("hdr_busy", busy, 1);
    for (int k = 0; k < stall; k++) begin
      #1 chk("stall_sready", s_ready, 0);
      chk("stall_vin", ins_valid_in, 0);
      chk("stall_hready", h_ready, 0);
      tick;
    end
    ins_ready_insert = 1;
    #1 chk("hdr_valid", ins_valid_insert, 1);
    chk("hdr_data", ins_data_insert, 32'h4800_0000 | 32'(g));
    chk("hdr_keep", ins_keep_insert, 32'(g + 3));
    chk("hdr_bcnt", ins_byte_insert_cnt, 32'(g));
    chk("hdr_hready", h_ready, 32'(1 << g));
    chk("hdr_sready", s_ready, 0);
    chk("hdr_vin", ins_valid_in, 0);
    tick;
    for (int b = 0; b < nbeats; b++) begin
      set_beat(b, b == nbeats-1);
      pkt_done = (b == nbeats-1) && (done_dly == 0);
      #1 chk("pl_valid", ins_valid_in, 1);
      chk("pl_data", ins_data_in, 32'hA000_0000 + 32'(g*256 + b));
      chk("pl_keep", ins_keep_in, 32'(g + 8));
      chk("pl_last", ins_last_in, 32'(b == nbeats-1));
      chk("pl_sready", s_ready, 32'(1 << g));
      chk("pl_vins", ins_valid_insert, 0);
      chk("pl_hready", h_ready, 0);
      tick;
    end
    pkt_done = 0; s_valid = '0; s_last = '0;
    if (done_dly > 0) begin
      for (int k = 1; k <= done_dly; k++) begin
        pkt_done = (k == done_dly);
        #1 chk("dr_busy", busy, 1);
        chk("dr_sready", s_ready, 0);
        chk("dr_hready", h_ready, 0);
        chk("dr_vin", ins_valid_in, 0);
        tick;
      end
      pkt_done = 0;
    end else if (done_dly < 0) begin
      n = 0;
      while (busy && n < 50) begin
        chk("dr_err_early", err_timeout, 0);
        n++;
        tick;
      end
      chk("timeout_cycles", n, TO);
      chk("err_timeout", err_timeout, 1);
    end
    #1 chk("end_idle", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      h_data[32*i +: 32] = 32'h4800_0000 | 32'(i);
      h_keep[4*i +: 4]   = 4'(i + 3);
      h_bcnt[2*i +: 2]   = 2'(i);
      s_keep[4*i +: 4]   = 4'(i + 8);
    end
    tbl[0] = '{4'b1111, 0}; tbl[1] = '{4'b0001, 0};
    tbl[2] = '{4'b1100, 2}; tbl[3] = '{4'b0110, 1};
    tbl[4] = '{4'b1001, 3}; tbl[5] = '{4'b1010, 1};
    tbl[6] = '{4'b0011, 0}; tbl[7] = '{4'b1000, 3};

    do_reset;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_hready", h_ready, 0);

    // round-robin vectors, single-beat packets with pkt_done on the last beat
    for (int v = 0; v < 8; v++) begin
      h_valid = tbl[v].req;
      do_pkt(tbl[v].gnt, 1, 0, 0);
    end
    h_valid = '0;

    // only src2 requests, 3 beats, pkt_done one cycle after last; then rr_ptr must be 3
    do_reset;
    h_valid = 4'b0100;
    do_pkt(2, 3, 1, 0);
    h_valid = 4'b1001;
    do_pkt(3, 1, 0, 0);

    // all four request continuously
    do_reset;
    h_valid = 4'b1111;
    do_pkt(0, 2, 0, 0);
    do_pkt(1, 2, 2, 0);
    do_pkt(2, 2, 0, 0);
    do_pkt(3, 2, 1, 0);
    do_pkt(0, 2, 0, 0);

    // src1 payload valid while its header is stalled
    do_reset;
    h_valid = 4'b0010;
    do_pkt(1, 2, 0, 3);

    // DRAIN timeout, then the next source is granted
    do_reset;
    h_valid = 4'b0011;
    do_pkt(0, 2, -1, 0);
    do_pkt(1, 1, 0, 0);
    chk("err_sticky", err_timeout, 1);

    // reset mid-payload
    do_reset;
    h_valid = 4'b0100; ins_ready_insert = 1; ins_ready_in = 1; s_valid = '1; set_beat(0, 0);
    tick; tick;
    #1 chk("mid_sready", s_ready, 4'b0100);
    rstn = 0;
    #1 chk("arst_sready", s_ready, 0);
    chk("arst_hready", h_ready, 0);
    chk("arst_vin", ins_valid_in, 0);
    chk("arst_vins", ins_valid_insert, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 0);
    tick;
    rstn = 1; h_valid = 4'b1111;
    tick;
    chk("post_rst_grant", grant_id, 0);
    chk("post_rst_busy", busy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
